// File: rtl/fp_div_issue_pkg.sv
// Shared FP32 field positions, special constants and issue-FSM state encoding.
// Flag helper exists only when FP_DIV_ISSUE_FLAGS_EN is defined.
package fp_div_issue_pkg;

    localparam int          EXP_HI    = 30;
    localparam int          EXP_LO    = 23;
    localparam int          MANT_HI   = 22;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] CANON_NAN = 32'hFFC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_DONE,
        ST_HOLD
    } state_e;

`ifdef FP_DIV_ISSUE_FLAGS_EN
    // Returns {invalid, div_by_zero} for a / b.
    function automatic logic [1:0] calc_flags(input logic [31:0] a, input logic [31:0] b);
        logic a_max, b_max, a_mz, b_mz, a_ez, b_ez;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv;
        a_max  = (a[EXP_HI:EXP_LO] == EXP_MAX);
        b_max  = (b[EXP_HI:EXP_LO] == EXP_MAX);
        a_ez   = (a[EXP_HI:EXP_LO] == 8'h00);
        b_ez   = (b[EXP_HI:EXP_LO] == 8'h00);
        a_mz   = (a[MANT_HI:0] == 23'h0);
        b_mz   = (b[MANT_HI:0] == 23'h0);
        a_nan  = a_max && !a_mz;
        b_nan  = b_max && !b_mz;
        a_inf  = a_max && a_mz;
        b_inf  = b_max && b_mz;
        a_zero = a_ez && a_mz;
        b_zero = b_ez && b_mz;
        inv    = a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero);
        return {inv, b_zero && !a_zero && !a_max && !inv};
    endfunction
`endif

endpackage

// File: rtl/fp_req_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty at wrap.
// Pushes while full and pops while empty are ignored.
module fp_req_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[PW-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-2:0]] <= din;
    end

endmodule

// File: rtl/fp_div_issue.sv
// Request FIFO + start/done sequencer in front of the iterative fp_div unit.
// Define FP_DIV_ISSUE_FLAGS_EN to compute and return {invalid, div_by_zero} flags.
module fp_div_issue
    import fp_div_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_res,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef FP_DIV_ISSUE_FLAGS_EN
    output logic [1:0]       rsp_flags,
`endif
    output logic             div_start,
    output logic [31:0]      div_op_a,
    output logic [31:0]      div_op_b,
    input  logic             div_done,
    input  logic [31:0]      div_res,
    output logic             busy
);
`ifdef FP_DIV_ISSUE_FLAGS_EN
    localparam int ENTRY_W = 64 + TAG_W + 2;
`else
    localparam int ENTRY_W = 64 + TAG_W;
`endif

    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;

    state_e             state_q, state_d;
    logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_res_q, rsp_res_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
`ifdef FP_DIV_ISSUE_FLAGS_EN
    logic [1:0]         flags_q, flags_d, rsp_flags_q, rsp_flags_d;

    assign fifo_din  = {calc_flags(req_a, req_b), req_tag, req_b, req_a};
    assign rsp_flags = rsp_flags_q;
`else
    assign fifo_din  = {req_tag, req_b, req_a};
`endif

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;

    fp_req_fifo #(.DEPTH(DEPTH), .DATA_W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_tag_d   = rsp_tag_q;
        fifo_pop    = 1'b0;
`ifdef FP_DIV_ISSUE_FLAGS_EN
        flags_d     = flags_q;
        rsp_flags_d = rsp_flags_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // div_done high means the divider is idle and may take a start.
                if (!fifo_empty && div_done) begin
                    fifo_pop = 1'b1;
                    op_a_d   = fifo_dout[31:0];
                    op_b_d   = fifo_dout[63:32];
                    tag_d    = fifo_dout[64 +: TAG_W];
`ifdef FP_DIV_ISSUE_FLAGS_EN
                    flags_d  = fifo_dout[64 + TAG_W +: 2];
`endif
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE:    state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (div_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = div_res;
                    rsp_tag_d   = tag_q;
`ifdef FP_DIV_ISSUE_FLAGS_EN
                    rsp_flags_d = flags_q;
`endif
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_tag_q   <= '0;
`ifdef FP_DIV_ISSUE_FLAGS_EN
            flags_q     <= '0;
            rsp_flags_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_tag_q   <= rsp_tag_d;
`ifdef FP_DIV_ISSUE_FLAGS_EN
            flags_q     <= flags_d;
            rsp_flags_q <= rsp_flags_d;
`endif
        end
    end

    assign div_start = (state_q == ST_ISSUE);
    assign div_op_a  = op_a_q;
    assign div_op_b  = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_tag   = rsp_tag_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE) || rsp_valid_q;

endmodule
